pipelined_cpu_top: RTL and testbench

- Five-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset pipelined processor top.
- Contains the PC, 32x32 register file, ALU, forwarding/hazard unit, pipeline registers and an internal data memory.
- Instruction memory is external, read combinationally.
- Exposes debug observation ports for PC, EX-stage ALU result and any register.

---
 rtl/pipelined_cpu_top.sv | 237 +++++++++++++++++++++++
 tb/tb_pipelined_cpu_top.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cpu_top.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with EX operand forwarding,
// load-use stall, ID-resolved jumps, EX-resolved branches and an internal data memory.
module pipelined_cpu_top #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_alu_out_exec,
  input  logic [4:0]  dbg_reg_sel,
  output logic [31:0] dbg_reg_data
);
  localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  typedef enum logic [2:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic        useimm;
    logic        branch;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc4;
  } idex_t;

  typedef struct packed {
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] store;
  } exmem_t;

  typedef struct packed {
    logic        regwr;
    logic [4:0]  dest;
    logic [31:0] data;
  } memwb_t;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  idex_t       r_idex;
  exmem_t      r_exmem;
  memwb_t      r_memwb;
  logic [31:0] r_rf   [32];
  logic [31:0] r_dmem [DMEM_WORDS];

  logic [31:0]        w_pc4;
  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic [31:0]        w_j_target;
  idex_t              w_dec;
  logic               w_dec_jump;
  logic               w_use_rs;
  logic               w_use_rt;
  logic               w_stall;
  logic signed [31:0] w_fwd_a;
  logic signed [31:0] w_fwd_b;
  logic signed [31:0] w_alu_b;
  logic [31:0]        w_alu_out;
  logic               w_br_taken;
  logic [31:0]        w_br_target;
  logic [AW-1:0]      w_dmem_idx;
  logic [31:0]        w_wb_data;

  assign w_pc4        = r_pc + 32'd4;
  assign imem_addr    = r_pc;
  assign dbg_pc       = r_pc;
  assign dbg_reg_data = r_rf[dbg_reg_sel];

  // ID: decode, register read with same-cycle WB bypass
  assign w_op       = r_ifid_instr[31:26];
  assign w_funct    = r_ifid_instr[5:0];
  assign w_rs       = r_ifid_instr[25:21];
  assign w_rt       = r_ifid_instr[20:16];
  assign w_j_target = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};

  always_comb begin
    w_dec       = '0;
    w_dec_jump  = 1'b0;
    w_use_rs    = 1'b0;
    w_use_rt    = 1'b0;
    w_dec.rs    = w_rs;
    w_dec.rt    = w_rt;
    w_dec.shamt = r_ifid_instr[10:6];
    w_dec.imm   = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    w_dec.pc4   = r_ifid_pc4;
    w_dec.a     = (r_memwb.regwr && r_memwb.dest == w_rs) ? r_memwb.data : r_rf[w_rs];
    w_dec.b     = (r_memwb.regwr && r_memwb.dest == w_rt) ? r_memwb.data : r_rf[w_rt];
    case (w_op)
      6'h00: begin
        w_dec.dest  = r_ifid_instr[15:11];
        w_dec.regwr = 1'b1;
        w_use_rs    = 1'b1;
        w_use_rt    = 1'b1;
        case (w_funct)
          6'h20:   w_dec.op = ALU_ADD;
          6'h22:   w_dec.op = ALU_SUB;
          6'h24:   w_dec.op = ALU_AND;
          6'h25:   w_dec.op = ALU_OR;
          6'h2A:   w_dec.op = ALU_SLT;
          6'h00:   w_dec.op = ALU_SLL;
          default: begin
            w_dec.regwr = 1'b0;
            w_use_rs    = 1'b0;
            w_use_rt    = 1'b0;
          end
        endcase
      end
      6'h08, 6'h23: begin
        w_dec.op     = ALU_ADD;
        w_dec.useimm = 1'b1;
        w_dec.regwr  = 1'b1;
        w_dec.memrd  = (w_op == 6'h23);
        w_dec.dest   = w_rt;
        w_use_rs     = 1'b1;
      end
      6'h2B: begin
        w_dec.op     = ALU_ADD;
        w_dec.useimm = 1'b1;
        w_dec.memwr  = 1'b1;
        w_use_rs     = 1'b1;
        w_use_rt     = 1'b1;
      end
      6'h04: begin
        w_dec.branch = 1'b1;
        w_use_rs     = 1'b1;
        w_use_rt     = 1'b1;
      end
      6'h02:   w_dec_jump = 1'b1;
      default: ;
    endcase
    if (w_dec.dest == 5'd0) w_dec.regwr = 1'b0;
  end

  assign w_stall = r_idex.memrd &&
                   ((w_use_rs && r_idex.rt == w_rs) || (w_use_rt && r_idex.rt == w_rt));

  // EX: forwarding (EX/MEM over MEM/WB over ID/EX), ALU and branch resolution
  assign w_fwd_a = (r_exmem.regwr && r_exmem.dest == r_idex.rs) ? r_exmem.alu :
                   (r_memwb.regwr && r_memwb.dest == r_idex.rs) ? r_memwb.data : r_idex.a;
  assign w_fwd_b = (r_exmem.regwr && r_exmem.dest == r_idex.rt) ? r_exmem.alu :
                   (r_memwb.regwr && r_memwb.dest == r_idex.rt) ? r_memwb.data : r_idex.b;
  assign w_alu_b = r_idex.useimm ? r_idex.imm : w_fwd_b;

  always_comb begin
    w_alu_out = '0;
    case (r_idex.op)
      ALU_ADD: w_alu_out = w_fwd_a + w_alu_b;
      ALU_SUB: w_alu_out = w_fwd_a - w_alu_b;
      ALU_AND: w_alu_out = w_fwd_a & w_alu_b;
      ALU_OR:  w_alu_out = w_fwd_a | w_alu_b;
      ALU_SLT: w_alu_out = {31'd0, (w_fwd_a < w_alu_b)};
      ALU_SLL: w_alu_out = w_fwd_b << r_idex.shamt;
      default: w_alu_out = '0;
    endcase
  end

  assign dbg_alu_out_exec = w_alu_out;
  assign w_br_taken  = r_idex.branch && (w_fwd_a == w_fwd_b);
  assign w_br_target = r_idex.pc4 + {r_idex.imm[29:0], 2'b00};

  // MEM: word index wraps modulo the memory depth
  assign w_dmem_idx = AW'(r_exmem.alu[31:2] % 30'(DMEM_WORDS));
  assign w_wb_data  = r_exmem.memrd ? r_dmem[w_dmem_idx] : r_exmem.alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= pc_start;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_idex       <= '0;
      r_exmem      <= '0;
      r_memwb      <= '0;
    end else begin
      if (w_br_taken) begin
        r_pc         <= w_br_target;
        r_ifid_instr <= '0;
        r_ifid_pc4   <= '0;
      end else if (w_stall) begin
        r_pc         <= r_pc;
      end else if (w_dec_jump) begin
        r_pc         <= w_j_target;
        r_ifid_instr <= '0;
        r_ifid_pc4   <= '0;
      end else begin
        r_pc         <= w_pc4;
        r_ifid_instr <= imem_rdata;
        r_ifid_pc4   <= w_pc4;
      end
      r_idex        <= (w_br_taken || w_stall) ? '0 : w_dec;
      r_exmem.regwr <= r_idex.regwr;
      r_exmem.memrd <= r_idex.memrd;
      r_exmem.memwr <= r_idex.memwr;
      r_exmem.dest  <= r_idex.dest;
      r_exmem.alu   <= w_alu_out;
      r_exmem.store <= w_fwd_b;
      r_memwb.regwr <= r_exmem.regwr;
      r_memwb.dest  <= r_exmem.dest;
      r_memwb.data  <= w_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (r_memwb.regwr) begin
      r_rf[r_memwb.dest] <= r_memwb.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) r_dmem[i] <= '0;
    end else if (r_exmem.memwr) begin
      r_dmem[w_dmem_idx] <= r_exmem.store;
    end
  end

endmodule

// File: tb/tb_pipelined_cpu_top.sv
// Bench for pipelined_cpu_top: directed programs with known results plus random
// programs compared against an instruction-level reference model.
module tb_pipelined_cpu_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_start = 32'd600;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] dbg_pc;
  logic [31:0] dbg_alu_out_exec;
  logic [4:0]  dbg_reg_sel = 5'd0;
  logic [31:0] dbg_reg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog [0:63];
  int          prog_len = 0;
  logic [31:0] m_rf  [32];
  logic [31:0] m_mem [64];
  logic [31:0] w_off;

  pipelined_cpu_top #(.DMEM_WORDS(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_start         (pc_start),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .dbg_pc           (dbg_pc),
    .dbg_alu_out_exec (dbg_alu_out_exec),
    .dbg_reg_sel      (dbg_reg_sel),
    .dbg_reg_data     (dbg_reg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    w_off      = (imem_addr - pc_start) >> 2;
    imem_rdata = 32'h0;
    if (w_off < 32'(prog_len)) imem_rdata = prog[w_off[5:0]];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input int f, input int rs, input int rt,
                                        input int rd, input int sh);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], f[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] addr);
    return {6'h02, addr[27:2]};
  endfunction

  task automatic push(input logic [31:0] ins);
    prog[prog_len] = ins;
    prog_len++;
  endtask

  task automatic push_self_loop();
    push(enc_j(pc_start + 32'(4 * prog_len)));
  endtask

  task automatic do_reset(input logic [31:0] base);
    @(negedge clk);
    pc_start = base;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_reg_sel = 5'(r);
    #1;
    v = dbg_reg_data;
  endtask

  // Architectural reference: executes one instruction at a time until the self-loop jump.
  task automatic model_run(input logic [31:0] base);
    logic [31:0] pc, npc, ins, a, b, imm, wv, addr;
    int          rs, rt, rd, sh, wd;
    bit          wr, done;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = 0;
    pc   = base;
    done = 0;
    for (int step = 0; step < 500 && !done; step++) begin
      ins = (((pc - base) >> 2) < 32'(prog_len)) ? prog[((pc - base) >> 2)] : 32'h0;
      rs  = int'(ins[25:21]);
      rt  = int'(ins[20:16]);
      rd  = int'(ins[15:11]);
      sh  = int'(ins[10:6]);
      a   = m_rf[rs];
      b   = m_rf[rt];
      imm = {{16{ins[15]}}, ins[15:0]};
      npc = pc + 4;
      wr  = 0;
      wd  = 0;
      wv  = 0;
      addr = a + imm;
      case (ins[31:26])
        6'h00: begin
          wr = 1;
          wd = rd;
          case (ins[5:0])
            6'h20:   wv = a + b;
            6'h22:   wv = a - b;
            6'h24:   wv = a & b;
            6'h25:   wv = a | b;
            6'h2A:   wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00:   wv = b << sh;
            default: wr = 0;
          endcase
        end
        6'h08: begin wr = 1; wd = rt; wv = addr; end
        6'h23: begin wr = 1; wd = rt; wv = m_mem[((addr >> 2) % 64)]; end
        6'h2B: m_mem[((addr >> 2) % 64)] = b;
        6'h04: if (a == b) npc = pc + 4 + (imm << 2);
        6'h02: begin
          npc = {npc[31:28], ins[25:0], 2'b00};
          if (npc == pc) done = 1;
        end
        default: ;
      endcase
      if (wr && wd != 0) m_rf[wd] = wv;
      pc = npc;
    end
  endtask

  task automatic load_fwd_prog();
    prog_len = 0;
    push(enc_i(8, 0, 19, 5));
    push(enc_i(8, 0, 20, 10));
    push(enc_i(8, 0, 21, 3));
    push(enc_r(6'h20, 20, 20, 22, 0));
    push(enc_r(6'h20, 22, 19, 22, 0));
    push(enc_r(6'h20, 22, 21, 23, 0));
    push_self_loop();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    prog_len = 0;
    pc_start = 32'd600;
    rst_n    = 1'b1;
    #1;
    rst_n    = 1'b0;
    #1;
    n_checks++;
    if (dbg_pc !== 32'd600) begin
      n_fail++; $display("FAIL reset_pc: got %0d expected 600", dbg_pc);
    end
    n_checks++;
    if (imem_addr !== 32'd600) begin
      n_fail++; $display("FAIL reset_imem_addr: got %0d expected 600", imem_addr);
    end
    n_checks++;
    if (dbg_alu_out_exec !== 32'd0) begin
      n_fail++; $display("FAIL reset_alu: got %h expected 0", dbg_alu_out_exec);
    end
    for (int r = 0; r < 32; r += 7) begin
      read_reg(r, v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", r, v);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    n_checks++;
    if (dbg_pc !== 32'd604) begin
      n_fail++; $display("FAIL pc_increment: got %0d expected 604", dbg_pc);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] v;
    logic [31:0] exp_v [5];
    exp_v = '{32'd5, 32'd10, 32'd3, 32'd25, 32'd28};
    load_fwd_prog();
    do_reset(32'd600);
    run(40);
    for (int i = 0; i < 5; i++) begin
      read_reg(19 + i, v);
      n_checks++;
      if (v !== exp_v[i]) begin
        n_fail++; $display("FAIL fwd_reg%0d: got %0d expected %0d", 19 + i, v, exp_v[i]);
      end
    end
    n_checks++;
    if (imem_addr !== dbg_pc) begin
      n_fail++; $display("FAIL imem_addr_eq_pc: got %h expected %h", imem_addr, dbg_pc);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] v;
    logic [31:0] tr [$];
    int          idx;
    prog_len = 0;
    push(enc_i(8, 0, 8, 7));
    push(enc_i(6'h2B, 0, 8, 8));
    push(enc_i(6'h23, 0, 9, 8));
    push(enc_r(6'h20, 9, 9, 10, 0));
    push_self_loop();
    do_reset(32'd800);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      tr.push_back(dbg_alu_out_exec);
    end
    @(negedge clk);
    idx = -1;
    for (int i = 2; i < tr.size(); i++)
      if (idx < 0 && tr[i] == 32'd14) idx = i;
    n_checks++;
    if (idx < 0) begin
      n_fail++; $display("FAIL load_use_result_seen: got none expected 14 on alu output");
    end else begin
      n_checks++;
      if (tr[idx-1] !== 32'd0 || tr[idx-2] !== 32'd8) begin
        n_fail++;
        $display("FAIL load_use_bubble: got %h,%h before result expected 8,0",
                 tr[idx-2], tr[idx-1]);
      end
    end
    read_reg(10, v);
    n_checks++;
    if (v !== 32'd14) begin
      n_fail++; $display("FAIL load_use_t2: got %0d expected 14", v);
    end
    read_reg(9, v);
    n_checks++;
    if (v !== 32'd7) begin
      n_fail++; $display("FAIL load_use_t1: got %0d expected 7", v);
    end
  endtask

  task automatic test_branch();
    logic [31:0] v;
    prog_len = 0;
    push(enc_i(8, 0, 8, 1));
    push(enc_i(4, 8, 8, 2));
    push(enc_i(8, 0, 9, 9));
    push(enc_i(8, 0, 9, 9));
    push(enc_i(8, 0, 10, 4));
    push_self_loop();
    do_reset(32'h100);
    run(30);
    read_reg(9, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL beq_taken_t1: got %0d expected 0", v);
    end
    read_reg(10, v);
    n_checks++;
    if (v !== 32'd4) begin
      n_fail++; $display("FAIL beq_taken_t2: got %0d expected 4", v);
    end
    prog_len = 0;
    push(enc_i(8, 0, 8, 1));
    push(enc_i(4, 8, 0, 2));
    push(enc_i(8, 0, 9, 9));
    push(enc_i(8, 0, 11, 9));
    push(enc_i(8, 0, 10, 4));
    push_self_loop();
    do_reset(32'h100);
    run(30);
    read_reg(9, v);
    n_checks++;
    if (v !== 32'd9) begin
      n_fail++; $display("FAIL beq_not_taken_t1: got %0d expected 9", v);
    end
    read_reg(11, v);
    n_checks++;
    if (v !== 32'd9) begin
      n_fail++; $display("FAIL beq_not_taken_t3: got %0d expected 9", v);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] v;
    prog_len = 0;
    push(enc_i(8, 0, 0, 5));
    push(enc_r(6'h20, 0, 0, 8, 0));
    push_self_loop();
    do_reset(32'd600);
    run(20);
    read_reg(0, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL zero_reg0: got %0d expected 0", v);
    end
    read_reg(8, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL zero_t0: got %0d expected 0", v);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    logic [31:0] exp_v [5];
    exp_v = '{32'd5, 32'd10, 32'd3, 32'd25, 32'd28};
    load_fwd_prog();
    do_reset(32'd600);
    run(12);
    read_reg(19, v);
    n_checks++;
    if (v !== 32'd5) begin
      n_fail++; $display("FAIL midrun_pre_s1: got %0d expected 5", v);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dbg_pc !== 32'd600) begin
      n_fail++; $display("FAIL midrun_pc: got %0d expected 600", dbg_pc);
    end
    for (int i = 0; i < 5; i++) begin
      read_reg(19 + i, v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL midrun_clear_reg%0d: got %0d expected 0", 19 + i, v);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(40);
    for (int i = 0; i < 5; i++) begin
      read_reg(19 + i, v);
      n_checks++;
      if (v !== exp_v[i]) begin
        n_fail++; $display("FAIL midrun_rerun_reg%0d: got %0d expected %0d", 19 + i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap_slt();
    logic [31:0] v;
    prog_len = 0;
    push(enc_i(8, 0, 8, -1));
    push(enc_r(6'h20, 8, 8, 9, 0));
    push(enc_r(6'h2A, 8, 0, 10, 0));
    push_self_loop();
    do_reset(32'd600);
    run(20);
    read_reg(9, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL wrap_t1: got %h expected fffffffe", v);
    end
    read_reg(10, v);
    n_checks++;
    if (v !== 32'd1) begin
      n_fail++; $display("FAIL slt_t2: got %0d expected 1", v);
    end
  endtask

  task automatic test_random();
    logic [31:0] v, base;
    logic [5:0]  fl [6];
    int          n, rs, rt, rd, tgt;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    n  = 14;
    for (int it = 0; it < 20; it++) begin
      base     = 32'(4 * $urandom_range(0, 4000));
      pc_start = base;
      prog_len = 0;
      for (int i = 0; i < n; i++) begin
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0, 1, 9: push(enc_r(int'(fl[$urandom_range(0, 5)]), rs, rt, rd,
                              int'($urandom_range(0, 31))));
          2, 3:    push(enc_i(8, rs, rt, int'($urandom_range(0, 65535))));
          4:       push(enc_i(6'h23, rs, rt, 4 * int'($urandom_range(0, 31)) - 64));
          5:       push(enc_i(6'h2B, rs, rt, 4 * int'($urandom_range(0, 31)) - 64));
          6:       push(enc_i(4, rs, rt, int'($urandom_range(0, n - 1 - i))));
          7: begin
            tgt = int'($urandom_range(i + 1, n));
            push(enc_j(base + 32'(4 * tgt)));
          end
          default: push(enc_i(6'h3F, rs, rt, 0));
        endcase
      end
      push_self_loop();
      model_run(base);
      do_reset(base);
      run(120);
      for (int r = 0; r < 32; r++) begin
        read_reg(r, v);
        n_checks++;
        if (v !== m_rf[r]) begin
          n_fail++; $display("FAIL random%0d_reg%0d: got %h expected %h", it, r, v, m_rf[r]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_reset_midrun();
    test_wrap_slt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
